// File: rtl/com_pkg.sv
// Shared constants and FSM state type for the centre-of-mass tracker.
package com_pkg;

    localparam int unsigned FRAME_WIDTH  = 320;
    localparam int unsigned FRAME_HEIGHT = 240;
    localparam int unsigned SUM_W        = 25;
    localparam int unsigned CNT_W        = 17;
    localparam int unsigned X_W          = 11;
    localparam int unsigned Y_W          = 10;
    localparam int unsigned Q_W          = X_W;

    typedef enum logic [1:0] {
        ACCUM,
        DIV_X,
        DIV_Y,
        EMIT
    } com_state_t;

endpackage

// File: rtl/com_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses 26 cycles after start.
module com_divider
    import com_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int unsigned STEP_W = 5;

    logic [SUM_W-1:0]  quot_q;
    logic [CNT_W-1:0]  rem_q;
    logic [CNT_W-1:0]  div_q;
    logic [STEP_W-1:0] steps_q;
    logic              running_q;

    logic [CNT_W:0]    shifted_c;
    logic [CNT_W-1:0]  trial_c;
    logic              fits_c;

    // One restoring step: shift in the next dividend bit and try a subtract.
    always_comb begin
        shifted_c = {rem_q, quot_q[SUM_W-1]};
        trial_c   = shifted_c[CNT_W-1:0] - div_q;
        fits_c    = (shifted_c >= {1'b0, div_q});
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            quot_q    <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            steps_q   <= '0;
            running_q <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quot_q    <= dividend;
                div_q     <= divisor;
                rem_q     <= '0;
                steps_q   <= STEP_W'(SUM_W);
                running_q <= 1'b1;
            end else if (running_q) begin
                quot_q  <= {quot_q[SUM_W-2:0], fits_c};
                rem_q   <= fits_c ? trial_c : shifted_c[CNT_W-1:0];
                steps_q <= steps_q - STEP_W'(1);
                if (steps_q == STEP_W'(1)) begin
                    running_q <= 1'b0;
                    done      <= 1'b1;
                end
            end
        end
    end

    assign quotient = quot_q[Q_W-1:0];

endmodule

// File: rtl/com_tracker.sv
// Per-frame centre of mass of masked pixels; optional temporal smoothing under COM_SMOOTH_EN.
module com_tracker
    import com_pkg::*;
#(
    parameter int unsigned MIN_PIXELS = 16
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    input  logic [X_W-1:0] hcount_in,
    input  logic [Y_W-1:0] vcount_in,
    input  logic           pixel_valid_in,
    input  logic           mask_in,
    output logic [X_W-1:0] x_com_out,
    output logic [Y_W-1:0] y_com_out,
    output logic           com_valid_out,
    output logic           com_lost_out,
    output logic           busy_out
);

    com_state_t       state, state_next;

    logic [SUM_W-1:0] sum_x, sum_y, snap_x, snap_y;
    logic [CNT_W-1:0] count, snap_cnt;
    logic [X_W-1:0]   x_raw;
    logic [Y_W-1:0]   y_raw;
    logic             start_q;
`ifdef COM_SMOOTH_EN
    logic             have_prev;
`endif

    logic             hit_c, end_c, enough_c;
    logic [SUM_W-1:0] tot_x_c, tot_y_c;
    logic [CNT_W-1:0] tot_cnt_c;
    logic             div_start_c, div_sel_y_c, div_done;
    logic [Q_W-1:0]   div_quot;

    // Running totals including the current pixel, so the end pixel counts.
    always_comb begin
        hit_c     = pixel_valid_in && mask_in;
        end_c     = pixel_valid_in && (hcount_in == X_W'(FRAME_WIDTH - 1))
                                   && (vcount_in == Y_W'(FRAME_HEIGHT - 1));
        tot_x_c   = sum_x + (hit_c ? SUM_W'(hcount_in) : '0);
        tot_y_c   = sum_y + (hit_c ? SUM_W'(vcount_in) : '0);
        tot_cnt_c = count + CNT_W'(hit_c);
        enough_c  = (tot_cnt_c >= CNT_W'(MIN_PIXELS));
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) state <= ACCUM;
        else           state <= state_next;
    end

    // Y division is launched in the same cycle the X quotient arrives.
    always_comb begin
        state_next  = state;
        div_start_c = start_q;
        div_sel_y_c = 1'b0;
        case (state)
            ACCUM: if (end_c && enough_c) state_next = DIV_X;
            DIV_X: if (div_done) begin
                state_next  = DIV_Y;
                div_start_c = 1'b1;
                div_sel_y_c = 1'b1;
            end
            DIV_Y: if (div_done) state_next = EMIT;
            EMIT:  state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    com_divider u_div (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .start    (div_start_c),
        .dividend (div_sel_y_c ? snap_y : snap_x),
        .divisor  (snap_cnt),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sum_x         <= '0;
            sum_y         <= '0;
            count         <= '0;
            snap_x        <= '0;
            snap_y        <= '0;
            snap_cnt      <= '0;
            x_raw         <= '0;
            y_raw         <= '0;
            start_q       <= 1'b0;
            x_com_out     <= '0;
            y_com_out     <= '0;
            com_valid_out <= 1'b0;
            com_lost_out  <= 1'b0;
            busy_out      <= 1'b0;
`ifdef COM_SMOOTH_EN
            have_prev     <= 1'b0;
`endif
        end else begin
            com_valid_out <= 1'b0;
            com_lost_out  <= 1'b0;
            start_q       <= (state == ACCUM) && (state_next == DIV_X);
            busy_out      <= (state_next != ACCUM);

            if (end_c) begin
                sum_x <= '0;
                sum_y <= '0;
                count <= '0;
            end else begin
                sum_x <= tot_x_c;
                sum_y <= tot_y_c;
                count <= tot_cnt_c;
            end

            // Frames ending while a division is running are dropped.
            if (end_c && state == ACCUM) begin
                snap_x   <= tot_x_c;
                snap_y   <= tot_y_c;
                snap_cnt <= tot_cnt_c;
                if (!enough_c) begin
                    com_lost_out <= 1'b1;
`ifdef COM_SMOOTH_EN
                    have_prev    <= 1'b0;
`endif
                end
            end

            if (div_done && state == DIV_X) x_raw <= div_quot;
            if (div_done && state == DIV_Y) y_raw <= div_quot[Y_W-1:0];

            if (state == EMIT) begin
                com_valid_out <= 1'b1;
`ifdef COM_SMOOTH_EN
                // The held outputs are the previous COM; average with it once seeded.
                if (have_prev) begin
                    x_com_out <= X_W'(({1'b0, x_com_out} + {1'b0, x_raw}) >> 1);
                    y_com_out <= Y_W'(({1'b0, y_com_out} + {1'b0, y_raw}) >> 1);
                end else begin
                    x_com_out <= x_raw;
                    y_com_out <= y_raw;
                end
                have_prev <= 1'b1;
`else
                x_com_out <= x_raw;
                y_com_out <= y_raw;
`endif
            end
        end
    end

endmodule

// File: doc/com_tracker.md
# com_tracker

Computes the centre of mass of the thresholded marker pixels in each 320×240 frame. It sits directly upstream of the BRAM compare stage and drives that stage's COM inputs: `x_com_in`, `y_com_in` and `com_valid_in`. Pixel coordinates and a 1-bit mask arrive in raster order from the filter/threshold stage. At each frame end the block divides the coordinate sums by the pixel count with a shared sequential divider, then emits one valid pulse.

## Interface
- `MIN_PIXELS`, default 16: minimum masked-pixel count for a frame to produce a COM.
- `clk_in` input 1: system clock.
- `rst_n_in` input 1: reset, synchronous, active-low.
- `hcount_in` input 11: pixel x, 0..319.
- `vcount_in` input 10: pixel y, 0..239.
- `pixel_valid_in` input 1: the coordinates and mask are valid this cycle.
- `mask_in` input 1: pixel belongs to the marker.
- `x_com_out` output 11: COM x, 0..319.
- `y_com_out` output 10: COM y, 0..239.
- `com_valid_out` output 1: one-cycle pulse, new COM on the outputs.
- `com_lost_out` output 1: one-cycle pulse, the frame had fewer than `MIN_PIXELS` masked pixels.
- `busy_out` output 1: a division is in progress.

## Operation
- Accumulators:
  - `sum_x` and `sum_y` are 25 bits; `count` is 17 bits.
  - On `pixel_valid_in && mask_in`, add `hcount_in` to `sum_x`, add `vcount_in` to `sum_y`, and increment `count`.
  - No overflow is possible for a 320×240 frame.
- End pixel: `pixel_valid_in && hcount_in==319 && vcount_in==239`.
  - The end pixel is included in the totals.
  - The totals are latched into snapshot registers.
  - The accumulators clear in the same cycle, so the next frame accumulates with no gap.
- FSM states: `ACCUM`, `DIV_X`, `DIV_Y`, `EMIT`.
  - `ACCUM` → `DIV_X` on the end pixel when the latched count ≥ `MIN_PIXELS`.
  - On the end pixel with count < `MIN_PIXELS`: pulse `com_lost_out` the next cycle, stay in `ACCUM`, and hold the outputs.
  - `DIV_X`: start the divider with `sum_x / count`, wait for `done`, store the quotient, go to `DIV_Y`.
  - `DIV_Y`: same with `sum_y / count`, then go to `EMIT`.
  - `EMIT`: register the outputs, pulse `com_valid_out`, return to `ACCUM`.
- Division is unsigned and floors the result. Quotients are ≤ 319 and ≤ 239 by construction; take the low 11 and 10 bits.
- `busy_out` is 1 in `DIV_X`, `DIV_Y` and `EMIT`.
- End pixel arriving while `busy_out` is high:
  - Accumulation still clears and restarts.
  - That frame's totals are discarded.
  - The in-progress division completes normally.
- `x_com_out` and `y_com_out` hold their last value between pulses.

## Timing
- End pixel accepted in cycle N:
  - FSM enters `DIV_X` at N+1; the divider starts at N+1.
  - Divider `done` pulses 26 cycles after `start`.
  - X result at N+27; the `DIV_Y` start is issued at N+27.
  - Y result at N+53.
  - `EMIT` at N+54; `com_valid_out` and the new outputs are visible at N+55.
- `com_lost_out` is high at N+1.
- Reset values: all outputs 0, FSM in `ACCUM`, accumulators and snapshots 0.
- Reset asserted at any point, including mid-division: everything returns to reset values on the next clock edge, the divider aborts, and no pulse is emitted.

## Configuration
- `COM_SMOOTH_EN` defined:
  - In `EMIT`, the emitted value is `(previous + new) >> 1` per axis, using 12- and 11-bit intermediate widths.
  - The first COM after reset or after a `com_lost_out` is emitted raw and seeds `previous`.
  - Latency is unchanged.
- `COM_SMOOTH_EN` undefined: the raw quotients are emitted.

## Structure
- `com_pkg` contains:
  - `FRAME_WIDTH`=320 and `FRAME_HEIGHT`=240.
  - Width constants: `SUM_W`=25, `CNT_W`=17.
  - The FSM state enum `com_state_t`.
- Sub-module `com_divider`:
  - Restoring divider, one quotient bit per cycle, 25-bit dividend, 17-bit divisor.
  - Handshake: `start` in, `done` one-cycle pulse out, `quotient` held until the next `start`.
  - Uses the same `clk_in` and `rst_n_in`.
  - Instantiated once and shared between the X and Y divisions.

## Test plan
- Single-pixel test, with `MIN_PIXELS`=1: one masked pixel at (100,50) in a full raster frame → `com_valid_out` at N+55 with x=100, y=50.
- 10×10 square at x 200..209, y 30..39 → x=204, y=34, `count`=100.
- 5 masked pixels with the default `MIN_PIXELS` → `com_lost_out` at N+1, no `com_valid_out`, outputs unchanged.
- Reset mid-division: pull `rst_n_in` low at N+20 → all outputs 0, no pulse; the next frame's COM is correct.
- Early end pixel: drive a second end pixel at N+10 → exactly one `com_valid_out`, carrying the first frame's COM.
- `COM_SMOOTH_EN` defined: consecutive frames with COM (100,40) then (200,80) → second pulse gives (150,60).
